// File: rtl/sem_icap_arbiter_if.sv
// sem_icap_arbiter_if: SEM, user and ICAP-side signals of the ICAP arbiter
interface sem_icap_arbiter_if;
  logic        sem_icap_request, sem_icap_grant, sem_icap_csib, sem_icap_rdwrb;
  logic [31:0] sem_icap_din, sem_icap_dout;
  logic        usr_req, usr_gnt, usr_csib, usr_rdwrb;
  logic [31:0] usr_din, usr_dout;
  logic        icap_csib, icap_rdwrb;
  logic [31:0] icap_din, icap_dout;
  logic [1:0]  icap_owner;
  logic        usr_timeout;
  modport slave (
    input  sem_icap_request, sem_icap_csib, sem_icap_rdwrb, sem_icap_din,
    input  usr_req, usr_csib, usr_rdwrb, usr_din, icap_dout,
    output sem_icap_grant, sem_icap_dout, usr_gnt, usr_dout,
    output icap_csib, icap_rdwrb, icap_din, icap_owner, usr_timeout
  );
  modport master (
    output sem_icap_request, sem_icap_csib, sem_icap_rdwrb, sem_icap_din,
    output usr_req, usr_csib, usr_rdwrb, usr_din, icap_dout,
    input  sem_icap_grant, sem_icap_dout, usr_gnt, usr_dout,
    input  icap_csib, icap_rdwrb, icap_din, icap_owner, usr_timeout
  );
endinterface

// File: rtl/sem_icap_arbiter.sv
// sem_icap_arbiter: shares one ICAP port between the SEM controller and a user requester,
// with a deselect gap between owners and a watchdog that revokes a user starving SEM
module sem_icap_arbiter #(
  parameter int          GAP_CYCLES  = 4,
  parameter logic [15:0] USR_TIMEOUT = 16'hFFFF
) (
  input logic               clk_icap,
  input logic               reset,
  sem_icap_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SEM_OWN, USR_OWN, GAP} state_t;
  state_t      state_q, state_d;
  logic [15:0] wd_q, wd_d;
  logic [3:0]  gap_q, gap_d;
  logic        sem_req_q, usr_req_q, blocked_q, blocked_d, last_usr_q, last_usr_d;
  logic        usr_ok, revoke;
  logic        sem_gnt_q, usr_gnt_q, csib_q, rdwrb_q, tmo_q;
  logic [1:0]  owner_q;
  logic [31:0] din_q;

  always_comb begin
    usr_ok     = usr_req_q && !blocked_q;
    revoke     = state_q == USR_OWN && bus.usr_req && bus.sem_icap_request &&
                 USR_TIMEOUT != 16'd0 && wd_q == USR_TIMEOUT - 16'd1;
    blocked_d  = revoke || (blocked_q && bus.usr_req);
    state_d    = state_q;
    wd_d       = wd_q;
    gap_d      = gap_q;
    last_usr_d = last_usr_q;
    case (state_q)
      IDLE: begin
        if (sem_req_q && (!usr_ok || last_usr_q)) begin
          state_d    = SEM_OWN;
          last_usr_d = 1'b0;
        end else if (usr_ok) begin
          state_d    = USR_OWN;
          last_usr_d = 1'b1;
          wd_d       = '0;
        end
      end
      SEM_OWN: begin
        if (!bus.sem_icap_request) begin
          state_d = GAP;
          gap_d   = 4'(GAP_CYCLES - 1);
        end
      end
      USR_OWN: begin
        if (!bus.usr_req || revoke) begin
          state_d = GAP;
          gap_d   = 4'(GAP_CYCLES - 1);
        end else wd_d = wd_q + 16'(bus.sem_icap_request);
      end
      default: begin
        if (gap_q == 4'd0) state_d = IDLE;
        else gap_d = gap_q - 4'd1;
      end
    endcase
  end

  // the ICAP mux follows the next state so a release or revoke deselects on that same edge
  always_ff @(posedge clk_icap or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wd_q       <= '0;
      gap_q      <= '0;
      sem_req_q  <= 1'b0;
      usr_req_q  <= 1'b0;
      blocked_q  <= 1'b0;
      last_usr_q <= 1'b1;
      sem_gnt_q  <= 1'b0;
      usr_gnt_q  <= 1'b0;
      owner_q    <= 2'b00;
      tmo_q      <= 1'b0;
      csib_q     <= 1'b1;
      rdwrb_q    <= 1'b1;
      din_q      <= '0;
    end else begin
      state_q    <= state_d;
      wd_q       <= wd_d;
      gap_q      <= gap_d;
      sem_req_q  <= bus.sem_icap_request;
      usr_req_q  <= bus.usr_req;
      blocked_q  <= blocked_d;
      last_usr_q <= last_usr_d;
      sem_gnt_q  <= state_d == SEM_OWN;
      usr_gnt_q  <= state_d == USR_OWN;
      owner_q    <= {state_d == USR_OWN, state_d == SEM_OWN};
      tmo_q      <= revoke;
      csib_q     <= state_d == SEM_OWN ? bus.sem_icap_csib : state_d == USR_OWN ? bus.usr_csib : 1'b1;
      rdwrb_q    <= state_d == SEM_OWN ? bus.sem_icap_rdwrb : state_d == USR_OWN ? bus.usr_rdwrb : rdwrb_q;
      din_q      <= state_d == SEM_OWN ? bus.sem_icap_din : state_d == USR_OWN ? bus.usr_din : din_q;
    end
  end

  assign bus.sem_icap_grant = sem_gnt_q;
  assign bus.usr_gnt        = usr_gnt_q;
  assign bus.icap_owner     = owner_q;
  assign bus.usr_timeout    = tmo_q;
  assign bus.icap_csib      = csib_q;
  assign bus.icap_rdwrb     = rdwrb_q;
  assign bus.icap_din       = din_q;
  assign bus.sem_icap_dout  = bus.icap_dout;
  assign bus.usr_dout       = bus.icap_dout;
endmodule

// File: tb/tb_sem_icap_arbiter.sv
// tb_sem_icap_arbiter: directed and random traffic scored against a timestamp-based ownership model
module tb_sem_icap_arbiter;
  localparam int G  = 4;
  localparam int TO = 16;

  typedef struct packed {
    logic        sg, ug;
    logic [1:0]  own;
    logic        cs, rd;
    logic [31:0] din;
    logic        tmo;
  } exp_t;

  logic clk = 1'b0, rst_a = 1'b1, rst_b = 1'b1;
  int   n_chk = 0, n_err = 0;
  exp_t q[$];

  sem_icap_arbiter_if ia();
  sem_icap_arbiter_if ib();

  sem_icap_arbiter #(.GAP_CYCLES(G), .USR_TIMEOUT(16'(TO))) dut_a (.clk_icap(clk), .reset(rst_a), .bus(ia));
  sem_icap_arbiter #(.GAP_CYCLES(G), .USR_TIMEOUT(16'd0))   dut_b (.clk_icap(clk), .reset(rst_b), .bus(ib));

  always #5 clk = ~clk;

  // model: owner 0 none, 1 SEM, 2 user; arbitration allowed from edge m_free onward
  int          m_owner, m_last, m_free, m_t, m_wd;
  logic        m_prev_sem, m_prev_usr, m_blk, m_rd;
  logic [31:0] m_din;

  function exp_t model_step();
    exp_t e;
    logic tmo, sem, usr, ue;
    tmo = 1'b0;
    if (rst_a) begin
      m_owner = 0; m_last = 2; m_free = 0; m_wd = 0;
      m_prev_sem = 0; m_prev_usr = 0; m_blk = 0; m_rd = 1; m_din = 0;
    end else begin
      sem = ia.sem_icap_request;
      usr = ia.usr_req;
      if (m_owner == 1 && !sem) begin
        m_owner = 0; m_free = m_t + G + 1;
      end else if (m_owner == 2) begin
        if (!usr) begin
          m_owner = 0; m_free = m_t + G + 1;
        end else begin
          if (sem) m_wd++;
          if (TO != 0 && m_wd == TO) begin
            m_owner = 0; m_free = m_t + G + 1; tmo = 1'b1;
          end
        end
      end else if (m_owner == 0 && m_t >= m_free) begin
        ue = m_prev_usr && !m_blk;
        if (m_prev_sem && (!ue || m_last == 2)) begin
          m_owner = 1; m_last = 1;
        end else if (ue) begin
          m_owner = 2; m_last = 2; m_wd = 0;
        end
      end
      m_blk = tmo || (m_blk && usr);
      m_prev_sem = sem;
      m_prev_usr = usr;
      if (m_owner == 1) begin m_rd = ia.sem_icap_rdwrb; m_din = ia.sem_icap_din; end
      if (m_owner == 2) begin m_rd = ia.usr_rdwrb; m_din = ia.usr_din; end
    end
    m_t++;
    e.sg  = m_owner == 1;
    e.ug  = m_owner == 2;
    e.own = {m_owner == 2, m_owner == 1};
    e.cs  = m_owner == 1 ? ia.sem_icap_csib : m_owner == 2 ? ia.usr_csib : 1'b1;
    e.rd  = m_rd;
    e.din = m_din;
    e.tmo = tmo;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e, a;
    if (q.size() != 0) begin
      e = q.pop_front();
      a = {ia.sem_icap_grant, ia.usr_gnt, ia.icap_owner, ia.icap_csib, ia.icap_rdwrb, ia.icap_din, ia.usr_timeout};
      n_chk++;
      if (a !== e) begin
        n_err++;
        $display("FAIL scoreboard t=%0t got sg=%b ug=%b own=%b cs=%b rd=%b din=%h tmo=%b want sg=%b ug=%b own=%b cs=%b rd=%b din=%h tmo=%b",
                 $time, a.sg, a.ug, a.own, a.cs, a.rd, a.din, a.tmo, e.sg, e.ug, e.own, e.cs, e.rd, e.din, e.tmo);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    logic [31:0] v;
    @(posedge clk);
    q.push_back(model_step());
    @(negedge clk);
    #2;
    v = $urandom;
    ia.icap_dout = v;
    #1;
    chk("sem_dout", ia.sem_icap_dout, v);
    chk("usr_dout", ia.usr_dout, v);
  endtask

  task automatic wait_for(input bit sem);
    for (int i = 0; i < 20 && !(sem ? ia.sem_icap_grant : ia.usr_gnt); i++) step();
  endtask

  initial begin
    {ia.sem_icap_request, ia.usr_req} = 2'b00;
    {ia.sem_icap_csib, ia.sem_icap_rdwrb, ia.usr_csib, ia.usr_rdwrb} = 4'hF;
    ia.sem_icap_din = '0; ia.usr_din = '0; ia.icap_dout = '0;
    {ib.sem_icap_request, ib.usr_req} = 2'b00;
    {ib.sem_icap_csib, ib.sem_icap_rdwrb, ib.usr_csib, ib.usr_rdwrb} = 4'hF;
    ib.sem_icap_din = '0; ib.usr_din = 32'h1234_5678; ib.icap_dout = '0;
    fork
      begin
        int g, n, bad;
        step(); step();
        chk("rst_csib", ia.icap_csib, 1);
        chk("rst_rdwrb", ia.icap_rdwrb, 1);
        chk("rst_din", ia.icap_din, 0);
        chk("rst_owner", ia.icap_owner, 0);
        chk("rst_grants", {ia.sem_icap_grant, ia.usr_gnt, ia.usr_timeout}, 0);
        rst_a = 0;
        ia.sem_icap_request = 1;
        step(); step();
        chk("sem_grant_2edges", ia.sem_icap_grant, 1);
        chk("sem_owner", ia.icap_owner, 2'b01);
        ia.sem_icap_csib = 0; ia.sem_icap_rdwrb = 0; ia.sem_icap_din = 32'hAA99_5566;
        step();
        chk("sem_path_csib", ia.icap_csib, 0);
        chk("sem_path_din", ia.icap_din, 32'hAA99_5566);
        step(); step();
        ia.sem_icap_csib = 1;
        step();
        ia.sem_icap_rdwrb = 1; ia.sem_icap_request = 0;
        step();
        chk("sem_release", ia.sem_icap_grant, 0);
        repeat (6) step();
        rst_a = 1; step(); rst_a = 0;
        ia.sem_icap_request = 1; ia.usr_req = 1;
        wait_for(1);
        chk("both_sem_first", {ia.sem_icap_grant, ia.usr_gnt}, 2'b10);
        ia.sem_icap_csib = 0;
        step(); step();
        chk("sem_csib_low", ia.icap_csib, 0);
        ia.sem_icap_request = 0;
        step();
        chk("forced_deselect", {ia.icap_csib, ia.sem_icap_grant}, 2'b10);
        ia.sem_icap_csib = 1;
        g = 0;
        for (int i = 0; i < 20 && !ia.usr_gnt; i++) begin
          if (ia.icap_owner == 2'b00 && ia.icap_csib) g++;
          step();
        end
        chk("gap_min", 32'(g >= G), 1);
        chk("usr_after_gap", ia.usr_gnt, 1);
        ia.usr_csib = 0; ia.usr_rdwrb = 0; ia.usr_din = 32'hDEAD_BEEF; ia.sem_icap_request = 1;
        n = 0;
        for (int i = 0; i < 40 && !ia.usr_timeout; i++) begin step(); n++; end
        chk("timeout_pulse", {ia.usr_timeout, ia.usr_gnt}, 2'b10);
        chk("timeout_cycles", n, TO);
        ia.usr_csib = 1; ia.usr_rdwrb = 1;
        wait_for(1);
        chk("sem_after_revoke", ia.sem_icap_grant, 1);
        step(); step(); step();
        ia.sem_icap_request = 0;
        bad = 0;
        repeat (20) begin step(); if (ia.usr_gnt) bad++; end
        chk("usr_blocked", bad, 0);
        ia.usr_req = 0; step(); ia.usr_req = 1;
        wait_for(0);
        chk("usr_unblocked", ia.usr_gnt, 1);
        ia.usr_csib = 0;
        step(); step();
        chk("usr_csib_low", ia.icap_csib, 0);
        rst_a = 1;
        #1;
        chk("async_rst_csib", ia.icap_csib, 1);
        chk("async_rst_gnt", ia.usr_gnt, 0);
        step(); step();
        {ia.sem_icap_request, ia.usr_req} = 2'b00;
        {ia.sem_icap_csib, ia.usr_csib} = 2'b11;
        rst_a = 0;
        repeat (1500) begin
          if ($urandom_range(7) == 0) ia.sem_icap_request = !ia.sem_icap_request;
          if ($urandom_range(7) == 0) ia.usr_req = !ia.usr_req;
          ia.sem_icap_csib = 1'($urandom_range(1));
          ia.usr_csib = 1'($urandom_range(1));
          ia.sem_icap_rdwrb = 1'($urandom_range(1));
          ia.usr_rdwrb = 1'($urandom_range(1));
          ia.sem_icap_din = $urandom;
          ia.usr_din = $urandom;
          step();
        end
      end
      begin
        int lost, pulses;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_b = 0;
        ib.usr_req = 1; ib.usr_csib = 0;
        for (int i = 0; i < 10 && !ib.usr_gnt; i++) @(negedge clk);
        chk("b_usr_grant", ib.usr_gnt, 1);
        ib.sem_icap_request = 1;
        lost = 0; pulses = 0;
        repeat (3000) begin
          @(negedge clk);
          if (!ib.usr_gnt) lost++;
          if (ib.usr_timeout) pulses++;
        end
        chk("b_no_revoke", lost, 0);
        chk("b_no_pulse", pulses, 0);
      end
    join
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
